// File: rtl/bottleneck_arbiter.sv
// Two-master arbiter in front of the 64-to-16-bit bottleneck bridge.
// A master keeps the grant for its whole bus cycle; priority rotates on a tie.
// Optional access timeout: define BOTTLENECK_ARB_TIMEOUT_EN to build the stall counter.
module bottleneck_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic        ClkI,
    input  logic        ResetI,
    input  logic        M0CycI,
    input  logic        M1CycI,
    input  logic        M0StbI,
    input  logic        M1StbI,
    input  logic        M0WeI,
    input  logic        M1WeI,
    input  logic [1:0]  M0SizI,
    input  logic [1:0]  M1SizI,
    input  logic        M0SignedI,
    input  logic        M1SignedI,
    input  logic [63:0] M0AdrI,
    input  logic [63:0] M1AdrI,
    input  logic [63:0] M0DatI,
    input  logic [63:0] M1DatI,
    output logic [63:0] M0DatO,
    output logic [63:0] M1DatO,
    output logic        M0AckO,
    output logic        M1AckO,
    output logic        M0ErrAlignO,
    output logic        M1ErrAlignO,
    output logic        M0ErrTimeoutO,
    output logic        M1ErrTimeoutO,
    output logic        SCycO,
    output logic        SStbO,
    output logic        SWeO,
    output logic        SSignedO,
    output logic [1:0]  SSizO,
    output logic [63:0] SAdrO,
    output logic [63:0] SDatO,
    input  logic [63:0] SDatI,
    input  logic        SAckI,
    input  logic        SErrAlignI,
    output logic [1:0]  GrantO
);

    // The counter must be able to reach TIMEOUT_CYCLES - 1.
    if (TIMEOUT_CYCLES < 2 || (TIMEOUT_CYCLES >> CNT_WIDTH) != 0) begin : g_param_check
        $error("bottleneck_arbiter: TIMEOUT_CYCLES must be >= 2 and fit in CNT_WIDTH bits");
    end

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

    state_e state_q, state_d;
    logic   last_g_q, last_g_d;  // 0: M0 was served last
    logic   gnt0, gnt1;
    logic   stb_raw;

    // Next-state: hold the grant until the owner drops Cyc, hand off directly if the other waits.
    always_comb begin
        state_d  = state_q;
        last_g_d = last_g_q;
        case (state_q)
            StIdle: begin
                if (M0CycI && M1CycI) begin
                    state_d = last_g_q ? StGrant0 : StGrant1;
                end else if (M0CycI) begin
                    state_d = StGrant0;
                end else if (M1CycI) begin
                    state_d = StGrant1;
                end
            end
            StGrant0: begin
                if (!M0CycI) begin
                    last_g_d = 1'b0;
                    state_d  = M1CycI ? StGrant1 : StIdle;
                end
            end
            StGrant1: begin
                if (!M1CycI) begin
                    last_g_d = 1'b1;
                    state_d  = M0CycI ? StGrant0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (ResetI) begin
            state_d  = StIdle;
            last_g_d = 1'b1;
        end
    end

    // State and last-served registers.
    always_ff @(posedge ClkI) begin
        state_q  <= state_d;
        last_g_q <= last_g_d;
    end

    // Reset gates every output combinationally, so grants vanish in the reset cycle itself.
    assign gnt0   = (state_q == StGrant0) && !ResetI;
    assign gnt1   = (state_q == StGrant1) && !ResetI;
    assign GrantO = {gnt1, gnt0};

    // Master-to-bridge request mux and bridge-to-master response routing.
    always_comb begin
        SCycO       = 1'b0;
        stb_raw     = 1'b0;
        SWeO        = 1'b0;
        SSignedO    = 1'b0;
        SSizO       = 2'b00;
        SAdrO       = '0;
        SDatO       = '0;
        M0AckO      = 1'b0;
        M1AckO      = 1'b0;
        M0ErrAlignO = 1'b0;
        M1ErrAlignO = 1'b0;
        if (gnt0) begin
            SCycO       = M0CycI;
            stb_raw     = M0StbI;
            SWeO        = M0WeI;
            SSignedO    = M0SignedI;
            SSizO       = M0SizI;
            SAdrO       = M0AdrI;
            SDatO       = M0DatI;
            M0AckO      = SAckI & M0StbI;
            M0ErrAlignO = SErrAlignI & M0StbI;
        end else if (gnt1) begin
            SCycO       = M1CycI;
            stb_raw     = M1StbI;
            SWeO        = M1WeI;
            SSignedO    = M1SignedI;
            SSizO       = M1SizI;
            SAdrO       = M1AdrI;
            SDatO       = M1DatI;
            M1AckO      = SAckI & M1StbI;
            M1ErrAlignO = SErrAlignI & M1StbI;
        end
    end

    assign M0DatO = ResetI ? '0 : SDatI;
    assign M1DatO = ResetI ? '0 : SDatI;

`ifdef BOTTLENECK_ARB_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 kill_q, kill_d;  // strobe suppressed in the cycle after a timeout
    logic                 stall, timeout;

    // Stall counter: counts strobed cycles without any bridge response.
    always_comb begin
        stall   = stb_raw && !kill_q && !SAckI && !SErrAlignI;
        timeout = stall && (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
        kill_d  = timeout && !ResetI;
        if (ResetI || (state_d != state_q) || timeout || !stall) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout counter and strobe-kill registers.
    always_ff @(posedge ClkI) begin
        cnt_q  <= cnt_d;
        kill_q <= kill_d;
    end

    // Dropping the strobe for two cycles lets the bridge clear its progress bits.
    assign SStbO         = stb_raw && !timeout && !kill_q;
    assign M0ErrTimeoutO = timeout && gnt0;
    assign M1ErrTimeoutO = timeout && gnt1;
`else
    assign SStbO         = stb_raw;
    assign M0ErrTimeoutO = 1'b0;
    assign M1ErrTimeoutO = 1'b0;
`endif

endmodule

// File: tb/tb_bottleneck_arbiter.sv
// Directed bench for bottleneck_arbiter: vector table plus hand-written corner sequences.
module tb_bottleneck_arbiter;

    logic        ClkI = 1'b0;
    logic        ResetI = 1'b1;
    logic        M0CycI = 1'b0, M1CycI = 1'b0, M0StbI = 1'b0, M1StbI = 1'b0;
    logic        M0WeI = 1'b0, M1WeI = 1'b0, M0SignedI = 1'b0, M1SignedI = 1'b0;
    logic [1:0]  M0SizI = 2'b00, M1SizI = 2'b00;
    logic [63:0] M0AdrI = 64'h1000, M1AdrI = 64'h20;
    logic [63:0] M0DatI = 64'hA0A0, M1DatI = 64'hB1B1;
    logic [63:0] M0DatO, M1DatO;
    logic        M0AckO, M1AckO, M0ErrAlignO, M1ErrAlignO, M0ErrTimeoutO, M1ErrTimeoutO;
    logic        SCycO, SStbO, SWeO, SSignedO;
    logic [1:0]  SSizO;
    logic [63:0] SAdrO, SDatO;
    logic [63:0] SDatI = 64'h0;
    logic        SAckI = 1'b0, SErrAlignI = 1'b0;
    logic [1:0]  GrantO;

    int total = 0;
    int bad   = 0;

    bottleneck_arbiter #(
        .TIMEOUT_CYCLES(4),
        .CNT_WIDTH     (8)
    ) dut (
        .ClkI         (ClkI),
        .ResetI       (ResetI),
        .M0CycI       (M0CycI),
        .M1CycI       (M1CycI),
        .M0StbI       (M0StbI),
        .M1StbI       (M1StbI),
        .M0WeI        (M0WeI),
        .M1WeI        (M1WeI),
        .M0SizI       (M0SizI),
        .M1SizI       (M1SizI),
        .M0SignedI    (M0SignedI),
        .M1SignedI    (M1SignedI),
        .M0AdrI       (M0AdrI),
        .M1AdrI       (M1AdrI),
        .M0DatI       (M0DatI),
        .M1DatI       (M1DatI),
        .M0DatO       (M0DatO),
        .M1DatO       (M1DatO),
        .M0AckO       (M0AckO),
        .M1AckO       (M1AckO),
        .M0ErrAlignO  (M0ErrAlignO),
        .M1ErrAlignO  (M1ErrAlignO),
        .M0ErrTimeoutO(M0ErrTimeoutO),
        .M1ErrTimeoutO(M1ErrTimeoutO),
        .SCycO        (SCycO),
        .SStbO        (SStbO),
        .SWeO         (SWeO),
        .SSignedO     (SSignedO),
        .SSizO        (SSizO),
        .SAdrO        (SAdrO),
        .SDatO        (SDatO),
        .SDatI        (SDatI),
        .SAckI        (SAckI),
        .SErrAlignI   (SErrAlignI),
        .GrantO       (GrantO)
    );

    always #5 ClkI = ~ClkI;

    // in:  {rst, c0, s0, c1, s1, ack, err}
    // exp: {grant[1:0], scyc, sstb, ack0, ack1, err0, err1}
    typedef struct packed {
        logic [6:0] in;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge ClkI);
        #1;
    endtask

    function automatic logic [63:0] exp_adr(input logic [1:0] g);
        if (g == 2'b01) return 64'h1000;
        if (g == 2'b10) return 64'h20;
        return 64'h0;
    endfunction

    logic [1:0] exp_stb[6];
    logic [5:0] exp_to;

    initial begin
        tbl[0]  = '{in: 7'b1_00_00_00, exp: 8'b00_00_00_00};  // reset
        tbl[1]  = '{in: 7'b0_11_00_00, exp: 8'b00_00_00_00};  // M0 request seen, still idle
        tbl[2]  = '{in: 7'b0_11_00_00, exp: 8'b01_11_00_00};  // granted next cycle
        tbl[3]  = '{in: 7'b0_11_00_10, exp: 8'b01_11_10_00};  // ack to M0 only
        tbl[4]  = '{in: 7'b0_00_00_00, exp: 8'b01_00_00_00};  // M0 releases
        tbl[5]  = '{in: 7'b0_11_11_00, exp: 8'b00_00_00_00};  // tie, LastG=0
        tbl[6]  = '{in: 7'b0_11_11_00, exp: 8'b10_11_00_00};  // M1 wins tie
        tbl[7]  = '{in: 7'b0_11_11_10, exp: 8'b10_11_01_00};
        tbl[8]  = '{in: 7'b0_11_00_00, exp: 8'b10_00_00_00};  // M1 drops, handoff
        tbl[9]  = '{in: 7'b0_11_11_00, exp: 8'b01_11_00_00};  // no idle gap
        tbl[10] = '{in: 7'b0_11_11_10, exp: 8'b01_11_10_00};
        tbl[11] = '{in: 7'b0_10_11_10, exp: 8'b01_10_00_00};  // no strobe: ack masked, no preempt
        tbl[12] = '{in: 7'b0_00_11_00, exp: 8'b01_00_00_00};
        tbl[13] = '{in: 7'b0_11_11_11, exp: 8'b10_11_01_01};  // ack+err together
        tbl[14] = '{in: 7'b0_11_00_00, exp: 8'b10_00_00_00};
        tbl[15] = '{in: 7'b0_11_11_00, exp: 8'b01_11_00_00};
        tbl[16] = '{in: 7'b1_11_11_10, exp: 8'b00_00_00_00};  // reset mid-grant with ack
        tbl[17] = '{in: 7'b0_00_00_00, exp: 8'b00_00_00_00};

        for (int i = 0; i < 18; i++) begin
            {ResetI, M0CycI, M0StbI, M1CycI, M1StbI, SAckI, SErrAlignI} = tbl[i].in;
            @(negedge ClkI);
            chk($sformatf("vec%0d outputs", i),
                64'({GrantO, SCycO, SStbO, M0AckO, M1AckO, M0ErrAlignO, M1ErrAlignO}),
                64'(tbl[i].exp));
            chk($sformatf("vec%0d adr", i), SAdrO, exp_adr(tbl[i].exp[7:6]));
            chk($sformatf("vec%0d timeout", i), 64'({M0ErrTimeoutO, M1ErrTimeoutO}), 64'd0);
            next_cycle();
        end

        // M1 64-bit read while M0 waits, then reset mid-strobe.
        M1SizI = 2'b11; M1WeI = 1'b0; M0WeI = 1'b1;
        M1CycI = 1'b1; M1StbI = 1'b1;
        @(negedge ClkI);
        chk("m1 req idle grant", 64'(GrantO), 64'd0);
        next_cycle();
        M0CycI = 1'b1; M0StbI = 1'b1;
        @(negedge ClkI);
        chk("m1 grant", 64'(GrantO), 64'(2'b10));
        chk("m1 siz", 64'(SSizO), 64'(2'b11));
        chk("m1 adr", SAdrO, 64'h20);
        chk("m1 we", 64'(SWeO), 64'd0);
        next_cycle();
        SAckI = 1'b1; SDatI = 64'h1122334455667788;
        @(negedge ClkI);
        chk("m1 rdata", M1DatO, 64'h1122334455667788);
        chk("m1 ack", 64'({M0AckO, M1AckO}), 64'(2'b01));
        next_cycle();
        ResetI = 1'b1;
        @(negedge ClkI);
        chk("rst cyc/stb", 64'({SCycO, SStbO}), 64'd0);
        chk("rst acks", 64'({M0AckO, M1AckO}), 64'd0);
        chk("rst grant", 64'(GrantO), 64'd0);
        next_cycle();
        ResetI = 1'b0; SAckI = 1'b0;
        @(negedge ClkI);
        chk("post rst grant", 64'(GrantO), 64'd0);
        next_cycle();
        @(negedge ClkI);
        chk("post rst tie", 64'(GrantO), 64'(2'b01));
        chk("post rst we", 64'(SWeO), 64'd1);
        next_cycle();
        M0CycI = 1'b0; M0StbI = 1'b0; M1CycI = 1'b0; M1StbI = 1'b0;
        @(negedge ClkI);
        chk("release cyc", 64'({GrantO, SCycO}), 64'(3'b010));
        next_cycle();
        @(negedge ClkI);
        chk("back idle", 64'(GrantO), 64'd0);

        // Never-acked strobe from M0.
`ifdef BOTTLENECK_ARB_TIMEOUT_EN
        exp_stb = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
        exp_to  = 6'b000100;
`else
        exp_stb = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        exp_to  = 6'b000000;
`endif
        next_cycle();
        M0CycI = 1'b1; M0StbI = 1'b1;
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            @(negedge ClkI);
            chk($sformatf("stall%0d stb", k), 64'(SStbO), 64'(exp_stb[k][0]));
            chk($sformatf("stall%0d to", k), 64'({M1ErrTimeoutO, M0ErrTimeoutO}),
                64'({1'b0, exp_to[5-k]}));
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bottleneck_arbiter.md
Name: bottleneck_arbiter

Overview:
- Two-requester arbiter in front of the 64-to-16-bit bottleneck bridge's master port.
- Lets the Polaris instruction-fetch master (M0) and data master (M1) share one bridge.
- Grants the bridge to one master for the whole bus cycle, rotating priority between masters.
- Routes strobes, address, size and write data to the bridge, and returns ack, alignment error and read data to the granted master only.

Parameters:
- TIMEOUT_CYCLES, 255, cycles a strobed access may wait for SAckI/SErrAlignI before abort (timeout feature only); minimum 2.
- CNT_WIDTH, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- ClkI  in  1  system clock; all state on rising edge.
- ResetI  in  1  synchronous, active-high reset.
- M0CycI, M1CycI  in  1  master n bus cycle request.
- M0StbI, M1StbI  in  1  master n transfer strobe.
- M0WeI, M1WeI  in  1  master n write enable.
- M0SizI, M1SizI  in  2  size: 00=8, 01=16, 10=32, 11=64 bit.
- M0SignedI, M1SignedI  in  1  sign-extend read data.
- M0AdrI, M1AdrI  in  64  byte address.
- M0DatI, M1DatI  in  64  write data.
- M0DatO, M1DatO  out  64  read data; both driven from SDatI.
- M0AckO, M1AckO  out  1  transfer acknowledge.
- M0ErrAlignO, M1ErrAlignO  out  1  misaligned-access error.
- M0ErrTimeoutO, M1ErrTimeoutO  out  1  timeout abort pulse.
- SCycO, SStbO, SWeO, SSignedO  out  1  to bridge.
- SSizO  out  2  to bridge.
- SAdrO, SDatO  out  64  to bridge.
- SDatI  in  64  read data from bridge.
- SAckI, SErrAlignI  in  1  acknowledge / alignment error from bridge.
- GrantO  out  2  one-hot current grant (bit n = master n); 00 when idle.

Behaviour:
- State register: IDLE, GRANT0, GRANT1. Last-served flag LastG (0 = M0 served last).
- Reset values:
  - State = IDLE, LastG = 1, so M0 wins the first tie.
  - Counter = 0, GrantO = 00.
  - All outputs are 0 while ResetI is high, including combinational ones: S*O, M*AckO, M*Err*O = 0.
- IDLE:
  - No requests: stay in IDLE; SCycO = SStbO = 0 and all S* buses 0.
  - Only M0CycI: next state GRANT0. Only M1CycI: next state GRANT1.
  - Both requesting: grant the master not equal to LastG.
  - Arbitration latency: request seen at edge k; SCycO high from cycle k+1.
- GRANTn:
  - SCycO = MnCycI, SStbO = MnStbI, and SWeO/SSizO/SSignedO/SAdrO/SDatO = master n's inputs. These are combinational muxes with no added latency.
  - MnAckO = SAckI & MnStbI; MnErrAlignO = SErrAlignI & MnStbI.
  - The non-granted master sees Ack = Err = 0.
- End of grant:
  - Leave GRANTn when MnCycI = 0 at an edge; set LastG = n.
  - If the other master is requesting at that edge, go directly to its GRANT (back-to-back handoff, zero idle cycles). Otherwise go to IDLE.
- No preemption: a grant is held for any number of strobes while Cyc stays high. This covers multi-phase 32/64-bit transfers inside the bridge.
- The bridge's internal ack1..ack3 progress bits are cleared when SStbO drops. The arbiter therefore never changes the granted master while SStbO is high. A master dropping Cyc mid-transfer is its own fault; the grant is still released.
- Reset asserted mid-cycle: outputs are forced low the same cycle; state is IDLE after the edge; no ack reaches any master.
- Simultaneous SAckI and SErrAlignI: both pass through unchanged.

Optional Feature:
- Macro: BOTTLENECK_ARB_TIMEOUT_EN.
- Enabled:
  - Counter increments each cycle SStbO = 1 and SAckI = SErrAlignI = 0.
  - Counter clears on ack, on error, when SStbO = 0, and on state change.
  - When counter == TIMEOUT_CYCLES-1 with no ack, pulse MnErrTimeoutO for one cycle and force SStbO = 0 that cycle and the next. The bridge sequencer then resets its progress bits.
  - Counter then clears; the grant is kept until MnCycI drops.
- Disabled: the counter is not built; M0ErrTimeoutO = M1ErrTimeoutO = 0 always; ports remain.

Test Plan:
- Reset, then M0CycI = M0StbI = 1, M0AdrI = 0x1000, M0SizI = 00 -> GrantO = 01 next cycle; SAdrO = 0x1000; SAckI at cycle 3 -> M0AckO = 1, M1AckO = 0.
- M0 and M1 request the same cycle, from reset -> GRANT0 first. M0 drops Cyc -> GrantO = 10 on the very next cycle; no IDLE cycle.
- Round-robin: both masters hold Cyc continuously, each dropping Cyc after one ack -> grants alternate 01,10,01,10 over four transactions.
- M1 64-bit read at 0x20, SDatI = 0x1122334455667788 with SAckI -> M1DatO = that value, M1AckO = 1; M0, requesting meanwhile, sees no ack and waits.
- ResetI pulsed high while GRANT1 has SStbO = 1 -> SCycO = SStbO = 0 that cycle; GrantO = 00 after the edge; SAckI in the reset cycle produces no MnAckO.
- With BOTTLENECK_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 4, a strobe never acked -> M0ErrTimeoutO pulses on the 4th stalled cycle; SStbO is low for two cycles, then follows M0StbI again.
